// File: rtl/pc_unit_if.sv
// Fetch-stage PC unit bus: pipeline control in, fetch address and status out.
interface pc_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             PC_en;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_target;
    logic             exc_req;
    logic             eret;
    logic [WIDTH-1:0] epc;
    logic [WIDTH-1:0] PC;
    logic [WIDTH-1:0] PC4;
    logic             redirect_pending;
    logic             fetch_fault;

    modport master (
        output PC_en, redirect_valid, redirect_target, exc_req, eret, epc,
        input  PC, PC4, redirect_pending, fetch_fault
    );

    modport slave (
        input  PC_en, redirect_valid, redirect_target, exc_req, eret, epc,
        output PC, PC4, redirect_pending, fetch_fault
    );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit with stall-safe one-entry redirect buffer.
// Define PC_RANGE_CHECK_EN to build the fetch address range/alignment fault check.
module pc_unit #(
    parameter int unsigned      WIDTH          = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR   = 32'h0000_3000,
    parameter logic [WIDTH-1:0] HANDLER_VECTOR = 32'h0000_4180,
    parameter logic [WIDTH-1:0] IMEM_BASE      = 32'h0000_3000,
    parameter logic [WIDTH-1:0] IMEM_LIMIT     = 32'h0000_6FFF
) (
    input logic       clk,
    input logic       reset,
    pc_unit_if.slave  bus
);
    typedef enum logic {RUN, PEND} state_t;

    localparam logic [WIDTH-1:0] FOUR = {{(WIDTH-3){1'b0}}, 3'd4};

    state_t           state, state_nxt;
    logic [WIDTH-1:0] pc, pc_nxt;
    logic [WIDTH-1:0] pend_target, pend_nxt;
    logic [WIDTH-1:0] pc_plus4;

    assign pc_plus4 = pc + FOUR;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            pc          <= RESET_VECTOR;
            pend_target <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            pend_target <= pend_nxt;
        end
    end

    // Exception/eret bypass the stall; a redirect seen with exc_req is dropped, not buffered.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        pend_nxt  = pend_target;
        if (bus.exc_req) begin
            pc_nxt    = HANDLER_VECTOR;
            state_nxt = RUN;
            pend_nxt  = '0;
        end else if (bus.eret) begin
            pc_nxt    = bus.epc;
            state_nxt = RUN;
            pend_nxt  = '0;
        end else if (bus.PC_en) begin
            state_nxt = RUN;
            if (bus.redirect_valid) begin
                pc_nxt = bus.redirect_target;
            end else if (state == PEND) begin
                pc_nxt = pend_target;
            end else begin
                pc_nxt = pc_plus4;
            end
        end else if (bus.redirect_valid) begin
            pend_nxt  = bus.redirect_target;
            state_nxt = PEND;
        end
    end

    assign bus.PC               = pc;
    assign bus.PC4              = pc_plus4;
    assign bus.redirect_pending = (state == PEND);

`ifdef PC_RANGE_CHECK_EN
    assign bus.fetch_fault = (pc[1:0] != 2'b00) || (pc < IMEM_BASE) || (pc > IMEM_LIMIT);
`else
    assign bus.fetch_fault = 1'b0;
`endif
endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: stimulus queues expected PC/pending, a monitor compares after each edge.
module tb_pc_unit;
    logic clk;
    logic reset;

    pc_unit_if #(.WIDTH(32)) bus ();

    pc_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        pend;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    function automatic logic model_fault(input logic [31:0] pc);
`ifdef PC_RANGE_CHECK_EN
        return (pc[1:0] != 2'b00) || (pc < 32'h0000_3000) || (pc > 32'h0000_6FFF);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] pc, input logic pend);
        check({tag, " PC"}, bus.PC, pc);
        check({tag, " PC4"}, bus.PC4, pc + 32'd4);
        check({tag, " pending"}, {31'd0, bus.redirect_pending}, {31'd0, pend});
        check({tag, " fault"}, {31'd0, bus.fetch_fault}, {31'd0, model_fault(pc)});
    endtask

    // Monitor: one expectation per rising edge, sampled 2 time units after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_all("step", e.pc, e.pend);
            end
        end
    end

    task automatic step(input logic en, input logic rv, input logic [31:0] tgt,
                        input logic exc, input logic er, input logic [31:0] epc_v,
                        input logic [31:0] exp_pc, input logic exp_pend);
        exp_t e;
        bus.PC_en           = en;
        bus.redirect_valid  = rv;
        bus.redirect_target = tgt;
        bus.exc_req         = exc;
        bus.eret            = er;
        bus.epc             = epc_v;
        e.pc   = exp_pc;
        e.pend = exp_pend;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    initial begin
        reset               = 1'b1;
        bus.PC_en           = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = '0;
        bus.exc_req         = 1'b0;
        bus.eret            = 1'b0;
        bus.epc             = '0;
        repeat (2) @(posedge clk);
        #2;
        check_all("reset", 32'h0000_3000, 1'b0);

        @(negedge clk);
        reset = 1'b0;
        // reset and run
        step(1, 0, 32'h0, 0, 0, 32'h0, 32'h0000_3004, 0);
        step(1, 0, 32'h0, 0, 0, 32'h0, 32'h0000_3008, 0);
        step(1, 0, 32'h0, 0, 0, 32'h0, 32'h0000_300C, 0);
        // stalled redirect
        step(0, 1, 32'h3100, 0, 0, 32'h0, 32'h0000_300C, 1);
        step(0, 0, 32'h0, 0, 0, 32'h0, 32'h0000_300C, 1);
        step(0, 0, 32'h0, 0, 0, 32'h0, 32'h0000_300C, 1);
        step(1, 0, 32'h0, 0, 0, 32'h0, 32'h0000_3100, 0);
        step(1, 0, 32'h0, 0, 0, 32'h0, 32'h0000_3104, 0);
        // exception during stall with pending
        step(0, 1, 32'h3100, 0, 0, 32'h0, 32'h0000_3104, 1);
        step(0, 0, 32'h0, 1, 0, 32'h0, 32'h0000_4180, 0);
        step(1, 0, 32'h0, 0, 0, 32'h0, 32'h0000_4184, 0);
        // exception with a simultaneous stalled redirect drops the redirect
        step(0, 1, 32'h3200, 1, 0, 32'h0, 32'h0000_4180, 0);
        step(1, 0, 32'h0, 0, 0, 32'h0, 32'h0000_4184, 0);
        // eret versus exception
        step(1, 0, 32'h0, 1, 1, 32'h3050, 32'h0000_4180, 0);
        step(0, 0, 32'h0, 0, 1, 32'h3050, 32'h0000_3050, 0);
        step(1, 0, 32'h0, 0, 0, 32'h0, 32'h0000_3054, 0);
        // newer stalled target overwrites older pending one
        step(0, 1, 32'h3300, 0, 0, 32'h0, 32'h0000_3054, 1);
        step(0, 1, 32'h3400, 0, 0, 32'h0, 32'h0000_3054, 1);
        step(1, 0, 32'h0, 0, 0, 32'h0, 32'h0000_3400, 0);
        // fresh redirect beats pending one
        step(0, 1, 32'h3600, 0, 0, 32'h0, 32'h0000_3400, 1);
        step(1, 1, 32'h3700, 0, 0, 32'h0, 32'h0000_3700, 0);
        // fault boundaries
        step(1, 1, 32'h3002, 0, 0, 32'h0, 32'h0000_3002, 0);
        step(1, 1, 32'h7000, 0, 0, 32'h0, 32'h0000_7000, 0);
        step(1, 1, 32'h2FFC, 0, 0, 32'h0, 32'h0000_2FFC, 0);
        step(1, 0, 32'h0, 0, 0, 32'h0, 32'h0000_3000, 0);
        step(1, 1, 32'h6FFC, 0, 0, 32'h0, 32'h0000_6FFC, 0);
        step(1, 0, 32'h0, 0, 0, 32'h0, 32'h0000_7000, 0);
        // wrap
        step(1, 1, 32'hFFFF_FFFC, 0, 0, 32'h0, 32'hFFFF_FFFC, 0);
        step(1, 0, 32'h0, 0, 0, 32'h0, 32'h0000_0000, 0);
        // async reset while pending
        step(0, 1, 32'h3100, 0, 0, 32'h0, 32'h0000_0000, 1);
        bus.redirect_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_all("async reset", 32'h0000_3000, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        step(1, 0, 32'h0, 0, 0, 32'h0, 32'h0000_3004, 0);
        step(0, 0, 32'h0, 0, 0, 32'h0, 32'h0000_3004, 0);

        repeat (3) @(posedge clk);
        #3;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
